// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared widths, defaults and drain FSM state type for the UART
//               transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_BYTE_W       = 8;
    localparam int TXQ_DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Synchronous byte FIFO with registered fill flags, sticky
//               overflow and optional dropped-byte counter
//               (UART_TXQ_OVF_CNT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = TXQ_DEFAULT_DEPTH,
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_BYTE_W-1:0] wr_data,
    input  logic                   wr_en,
    input  logic                   pop,
    input  logic                   ovf_clr,
    output logic [UART_BYTE_W-1:0] rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        count,
    output logic                   overflow,
    output logic [7:0]             ovf_cnt
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    logic [UART_BYTE_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]      r_wr_ptr;
    logic [ADDR_W-1:0]      r_rd_ptr;
    logic [ADDR_W:0]        r_count;
    logic [ADDR_W:0]        w_count_nxt;
    logic                   r_full;
    logic                   r_empty;
    logic                   r_overflow;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_pop;

    // Full is judged on the registered count, so a same-cycle pop never rescues a write.
    assign w_push = wr_en && !r_full;
    assign w_drop = wr_en && r_full;
    assign w_pop  = pop && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (ADDR_W+1)'(1);
            2'b01:   w_count_nxt = r_count - (ADDR_W+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_depth);
            r_empty <= (w_count_nxt == '0);
            if (w_drop)       r_overflow <= 1'b1;
            else if (ovf_clr) r_overflow <= 1'b0;
        end
    end

    // Storage needs no reset: pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

`ifdef UART_TXQ_OVF_CNT_EN
    logic [7:0] r_ovf_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_cnt <= 8'h00;
        end else if (w_drop) begin
            if (ovf_clr)                r_ovf_cnt <= 8'h01;
            else if (r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'h01;
        end else if (ovf_clr) begin
            r_ovf_cnt <= 8'h00;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`else
    assign ovf_cnt = 8'h00;
`endif

    assign rd_data  = r_mem[r_rd_ptr];
    assign full     = r_full;
    assign empty    = r_empty;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_queue
// Description : Byte queue feeding a UART transmitter through a send/busy
//               handshake. Optional dropped-byte counter: UART_TXQ_OVF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH  = TXQ_DEFAULT_DEPTH,
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_BYTE_W-1:0] wr_data,
    input  logic                   wr_en,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        count,
    output logic                   overflow,
    input  logic                   ovf_clr,
    output logic [7:0]             ovf_cnt,
    output logic [UART_BYTE_W-1:0] tx_data,
    output logic                   tx_send,
    input  logic                   tx_busy
);

    drain_state_t           r_state;
    drain_state_t           w_state_nxt;
    logic                   w_pop;
    logic [UART_BYTE_W-1:0] w_rd_data;
    logic [UART_BYTE_W-1:0] r_tx_data;

    byte_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .pop      (w_pop),
        .ovf_clr  (ovf_clr),
        .rd_data  (w_rd_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .ovf_cnt  (ovf_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_tx_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) r_tx_data <= w_rd_data;
        end
    end

    // Send is held as a level in REQ; the transmitter only latches it while idle.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (tx_busy) w_state_nxt = WAIT;
            end
            WAIT: begin
                if (!tx_busy) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign tx_send = (r_state == REQ);
    assign tx_data = r_tx_data;

endmodule
`default_nettype wire
